// File: rtl/serial_operand_streamer.sv
// Feeds W-bit operand pairs MSB-first to a serial comparator and registers its final flags.
// Latency: transfer to res_valid is W+2 cycles; back-to-back frames stream with no bubble.
// Backpressure: in_ready drops while the single pending buffer is full.
module serial_operand_streamer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         ser_a,
  output logic         ser_b,
  output logic         ser_valid,
  output logic         ser_first,
  output logic         ser_last,
  output logic         cmp_clear,
  input  logic         cmp_a_less_b,
  input  logic         cmp_a_eq_b,
  input  logic         cmp_a_greater_b,
  output logic         res_valid,
  output logic         res_less,
  output logic         res_eq,
  output logic         res_greater
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   pa;
  logic [W-1:0]   pb;
  logic           pvalid;
  logic [W-1:0]   sa;
  logic [W-1:0]   sb;
  logic [CW-1:0]  cnt;
  logic           load;
  logic           xfer;

  assign in_ready  = ~pvalid;
  assign xfer      = in_valid & in_ready;
  assign cmp_clear = ~ser_valid | ser_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The pending pair is pulled in on the last bit so the next frame follows without a gap.
  always_comb begin
    state_nxt = state;
    ser_valid = 1'b0;
    ser_a     = 1'b0;
    ser_b     = 1'b0;
    ser_first = 1'b0;
    ser_last  = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        load = pvalid;
        if (pvalid) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_a     = sa[W-1];
        ser_b     = sb[W-1];
        ser_first = (cnt == CNT_TOP);
        ser_last  = (cnt == '0);
        load      = pvalid & (cnt == '0);
        if ((cnt == '0) && !pvalid) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  // xfer needs pvalid=0 and load needs pvalid=1, so they never collide on pvalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pa     <= '0;
      pb     <= '0;
      pvalid <= 1'b0;
      sa     <= '0;
      sb     <= '0;
      cnt    <= '0;
    end else begin
      if (xfer) begin
        pa     <= in_a;
        pb     <= in_b;
        pvalid <= 1'b1;
      end
      if (load) begin
        sa     <= pa;
        sb     <= pb;
        cnt    <= CNT_TOP;
        pvalid <= 1'b0;
      end else if (ser_valid) begin
        sa <= sa << 1;
        sb <= sb << 1;
        if (!ser_last) begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid   <= 1'b0;
      res_less    <= 1'b0;
      res_eq      <= 1'b0;
      res_greater <= 1'b0;
    end else begin
      res_valid <= ser_last;
      if (ser_last) begin
        res_less    <= cmp_a_less_b;
        res_eq      <= cmp_a_eq_b;
        res_greater <= cmp_a_greater_b;
      end
    end
  end

endmodule

// File: doc/serial_operand_streamer.md
# serial_operand_streamer

Upstream feeder and result collector for the MSB-first serial comparator. Accepts parallel W-bit operand pairs over a valid/ready handshake and buffers one pair while another is being shifted. Streams each pair MSB-first, one bit pair per cycle, and drives the comparator's synchronous clear so that every frame starts in the "equal" state. At the last bit it samples the comparator's three flags and presents them as a one-cycle registered result.

## Interface

Reset is asynchronous, active-high.

Parameters:
- W, 16, operand width in bits; W >= 1

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair offered
- in_ready  out  1  pending buffer empty; transfer when in_valid & in_ready at posedge
- in_a  in  W  operand a
- in_b  in  W  operand b
- ser_a  out  1  current bit of a (MSB first); 0 when ser_valid=0
- ser_b  out  1  current bit of b; 0 when ser_valid=0
- ser_valid  out  1  a bit pair is presented this cycle
- ser_first  out  1  bit W-1 is presented this cycle
- ser_last  out  1  bit 0 is presented this cycle
- cmp_clear  out  1  synchronous reset to the comparator; = ~ser_valid | ser_last (combinational)
- cmp_a_less_b  in  1  comparator flag, combinational from the current bit
- cmp_a_eq_b  in  1  comparator flag
- cmp_a_greater_b  in  1  comparator flag
- res_valid  out  1  one-cycle pulse: result of the frame that just finished
- res_less  out  1  registered result flag
- res_eq  out  1  registered result flag
- res_greater  out  1  registered result flag

## Operation

- Storage:
  - pending buffer: pa, pb, pvalid
  - shifters: sa, sb
  - bit counter: cnt, width $clog2(W) with a minimum of 1
  - FSM: IDLE, SHIFT
- Accept:
  - in_ready = ~pvalid.
  - On a transfer, pa/pb <= in_a/in_b and pvalid <= 1.
  - The block never accepts directly into the shifter.
- Load condition:
  - load = pvalid & (state==IDLE | ser_last).
  - On load: sa/sb <= pa/pb, cnt <= W-1, pvalid <= 0, state <= SHIFT.
  - A transfer and a load on the same edge cannot occur, because the transfer requires pvalid=0 and the load requires pvalid=1.
- SHIFT:
  - ser_a/ser_b = sa[W-1]/sb[W-1] and ser_valid = 1.
  - ser_first = (cnt==W-1); ser_last = (cnt==0).
  - Each edge: shift left by 1 and decrement cnt.
  - At ser_last with no load: state <= IDLE.
  - At ser_last with a load: stay in SHIFT with no bubble.
- IDLE:
  - ser_* = 0, ser_valid = 0, cmp_clear = 1. The comparator is held in "equal".
- Clear timing: cmp_clear is high during the last-bit cycle. The comparator's state returns to "equal" on that edge, while the last-bit flags are still valid combinationally in that cycle.
- Result capture:
  - On an edge where ser_last=1: res_less/eq/greater <= cmp_a_less_b/eq/greater and res_valid <= 1.
  - Otherwise res_valid <= 0 and the res flags hold their values.
- W=1: ser_first and ser_last are both high in the single bit cycle.

## Timing

- Reset values: state IDLE, pvalid=0 (so in_ready=1), cnt=0, sa=sb=0, res_valid=0, res_*=0. Combinational outputs under reset: ser_valid=0, ser_a=ser_b=0, cmp_clear=1.
- Single frame, transfer at edge E0:
  - Cycle 1: pvalid=1, in_ready=0.
  - Edge E1: load.
  - Cycles 2..W+1: bits, with ser_first in cycle 2 and ser_last in cycle W+1.
  - res_valid in cycle W+2.
- Latency from transfer to res_valid is W+2 cycles. Sustained throughput is one pair per W cycles with no gaps.
- in_ready returns high the cycle after a load.
- Reset mid-frame: asynchronous abort. The frame and pending data are discarded, and no res_valid is produced for them.
- Input behaviour under backpressure: in_a/in_b are ignored while in_ready=0. Nothing is lost or duplicated.

## Test plan

- Reset then idle:
  - Stimulus: rst pulse, hold in_valid=0 for 10 cycles.
  - Required: ser_valid=0, cmp_clear=1, in_ready=1, res_valid=0 throughout.
- Single frame, greater (W=16):
  - Stimulus: in_a=16'h6482, in_b=16'h6262.
  - Required: ser_a bit sequence 0110_0100_1000_0010, ser_first in cycle 2, ser_last in cycle 17; with the comparator attached, res_valid in cycle 18 with res_greater=1, res_less=0, res_eq=0.
- Equal and less:
  - Stimulus: pair 16'hA5A5/16'hA5A5, then pair 16'h0001/16'h8000.
  - Required: first pair gives res_eq=1; second pair gives res_less=1.
- Back-to-back:
  - Stimulus: in_valid held high with 3 pairs queued.
  - Required: transfers at E0, E2, E18; ser_valid continuous over cycles 2..49; res_valid pulses in cycles 18, 34, 50.
  - Required: the comparator sees cmp_clear only on ser_last cycles, so every frame starts in "equal".
- Backpressure:
  - Stimulus: in_valid held with data held stable while in_ready=0.
  - Required: each pair is serialized exactly once, in order.
- Reset mid-frame and W=1:
  - Stimulus: assert rst at cycle 8 of a frame; separately, run W=1 with 1/0 then 0/0.
  - Required: reset gives immediate idle outputs and no res_valid for the aborted frame.
  - Required (W=1): ser_first=ser_last=1 each bit cycle; results are greater, then equal.
